// File: rtl/front_panel_examine.sv
// Front-panel EXAMINE / EXAMINE NEXT controller: turns a switch edge into a
// single memory read and latches the returned byte onto the panel LEDs.
module front_panel_examine #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  examine,
    input  logic                  examine_next,
    input  logic [ADDR_WIDTH-1:0] addr_sw,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [ADDR_WIDTH-1:0] addr_leds,
    output logic [7:0]            data_leds,
    output logic                  examine_latch,
    output logic                  timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        examine_prev, examine_next_prev;
    logic        ex_req, nx_req;
    logic [15:0] wait_cnt;
    logic        wait_expired;

    assign ex_req       = examine & ~examine_prev;
    assign nx_req       = examine_next & ~examine_next_prev;
    assign wait_expired = (wait_cnt == LAST_CNT);

    always_comb begin
        state_nxt     = state;
        mem_rd        = 1'b0;
        examine_latch = 1'b0;
        case (state)
            IDLE:  if (ex_req || nx_req) state_nxt = ISSUE;
            ISSUE: begin
                mem_rd        = 1'b1;
                examine_latch = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                examine_latch = 1'b1;
                if (mem_rvalid || wait_expired) state_nxt = DONE;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            examine_prev      <= 1'b0;
            examine_next_prev <= 1'b0;
            mem_addr          <= '0;
            addr_leds         <= '0;
            data_leds         <= 8'h00;
            timeout           <= 1'b0;
            wait_cnt          <= 16'd0;
        end else begin
            state             <= state_nxt;
            // Prev levels track every cycle so edges seen while busy never replay later.
            examine_prev      <= examine;
            examine_next_prev <= examine_next;
            case (state)
                IDLE: begin
                    if (ex_req)      mem_addr <= addr_sw;
                    else if (nx_req) mem_addr <= addr_leds + 1'b1;
                end
                ISSUE: begin
                    timeout  <= 1'b0;
                    wait_cnt <= 16'd0;
                end
                WAIT: begin
                    // A response in the final counted cycle still beats the timeout.
                    if (mem_rvalid) begin
                        data_leds <= mem_rdata;
                        addr_leds <= mem_addr;
                    end else if (wait_expired) begin
                        data_leds <= 8'hFF;
                        addr_leds <= mem_addr;
                        timeout   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_front_panel_examine.sv
// Randomized bench for front_panel_examine against a transaction-level model
// counting cycles since each accepted request.
module tb_front_panel_examine;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset, examine, examine_next, mem_rvalid;
    logic [AW-1:0] addr_sw;
    logic [7:0]    mem_rdata;
    logic          mem_rd, examine_latch, timeout;
    logic [AW-1:0] mem_addr, addr_leds;
    logic [7:0]    data_leds;

    front_panel_examine #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .examine(examine), .examine_next(examine_next),
        .addr_sw(addr_sw), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .addr_leds(addr_leds),
        .data_leds(data_leds), .examine_latch(examine_latch), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: ownership is "busy" with an age counting cycles since the read
    // strobe; a one-cycle cool-down follows each completed read.
    bit          m_busy, m_cool, m_to, m_pe, m_pn;
    int          m_age;
    logic [AW-1:0] m_addr, m_la;
    logic [7:0]  m_ld;
    int          n_reads, n_timeouts;

    task automatic model_step();
        bit ex_e, nx_e;
        ex_e = examine && !m_pe;
        nx_e = examine_next && !m_pn;
        if (reset) begin
            m_busy = 0; m_cool = 0; m_to = 0; m_addr = '0; m_la = '0; m_ld = 8'h00;
            m_pe = 0; m_pn = 0; m_age = 0;
            return;
        end
        m_pe = examine;
        m_pn = examine_next;
        if (m_cool) m_cool = 0;
        else if (!m_busy) begin
            if (ex_e || nx_e) begin
                m_addr = ex_e ? addr_sw : AW'(m_la + 1);
                m_busy = 1;
                m_age  = 0;
            end
        end else if (m_age == 0) begin
            m_to  = 0;
            m_age = 1;
        end else if (mem_rvalid) begin
            m_la = m_addr; m_ld = mem_rdata; m_busy = 0; m_cool = 1; n_reads++;
        end else if (m_age == TO) begin
            m_la = m_addr; m_ld = 8'hFF; m_to = 1; m_busy = 0; m_cool = 1; n_timeouts++;
        end else m_age++;
    endtask

    task automatic compare_all();
        check("mem_rd", 32'(mem_rd), 32'(m_busy && m_age == 0));
        check("examine_latch", 32'(examine_latch), 32'(m_busy));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("addr_leds", 32'(addr_leds), 32'(m_la));
        check("data_leds", 32'(data_leds), 32'(m_ld));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    int pend;

    initial begin
        reset = 1'b1; examine = 1'b0; examine_next = 1'b0; addr_sw = 16'h1234;
        mem_rvalid = 1'b0; mem_rdata = 8'h00; pend = -1;
        n_reads = 0; n_timeouts = 0;
        repeat (2) begin
            @(posedge clk); model_step();
            @(negedge clk); compare_all();
        end
        reset = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            // Memory responder: answer each strobe after a random delay, which
            // sometimes exceeds the timeout; occasional stray rvalids too.
            mem_rvalid = 1'b0;
            if (mem_rd) pend = $urandom_range(0, 11);
            if (pend == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 8'($urandom);
                pend = -1;
            end else if (pend > 0) pend--;
            else if ($urandom_range(0, 15) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 8'($urandom);
            end
            reset = ($urandom_range(0, 249) == 0);
            if (reset) pend = -1;
            if ($urandom_range(0, 3) == 0) examine = ~examine;
            if ($urandom_range(0, 3) == 0) examine_next = ~examine_next;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: addr_sw = 16'hFFFF;
                    1: addr_sw = 16'h0000;
                    2: addr_sw = 16'hFFFE;
                    default: addr_sw = 16'($urandom);
                endcase
            end
            @(posedge clk); model_step();
            @(negedge clk); compare_all();
        end
        check("reads_seen", 32'(n_reads > 20), 32'd1);
        check("timeouts_seen", 32'(n_timeouts > 2), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/front_panel_examine.md
Name: front_panel_examine

Overview:
Front-panel EXAMINE / EXAMINE NEXT controller. This is the read-side counterpart of the panel DEPOSIT logic. On a switch edge it loads a memory address and issues a single-cycle read strobe. It then waits for the memory read response and latches the byte onto the data LEDs. It holds a latch output high while the panel owns the bus, so the CPU can be stalled during the access.

Parameters:
ADDR_WIDTH, 16, width of address switches, memory address and address LEDs
TIMEOUT_CYCLES, 255, max cycles in WAIT before the read is abandoned (1..65535)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
examine  input  1  debounced EXAMINE switch level
examine_next  input  1  debounced EXAMINE NEXT switch level
addr_sw  input  ADDR_WIDTH  address switches
mem_rdata  input  8  memory read data
mem_rvalid  input  1  mem_rdata valid this cycle
mem_rd  output  1  one-cycle read strobe
mem_addr  output  ADDR_WIDTH  read address, stable from ISSUE through WAIT
addr_leds  output  ADDR_WIDTH  last examined address
data_leds  output  8  last examined data
examine_latch  output  1  high while panel owns bus (ISSUE, WAIT)
timeout  output  1  last read timed out

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on rising clk only.
- Reset values: state=IDLE; mem_rd=0; mem_addr=0; addr_leds=0; data_leds=0; examine_latch=0; timeout=0; edge-detect registers=0; timeout counter=0.
- Edge detect: each switch has a registered previous level. A request is level=1 with prev=0. A held switch produces exactly one request.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE on an examine edge: mem_addr <= addr_sw, then go to ISSUE.
- IDLE on an examine_next edge: mem_addr <= addr_leds + 1, modulo 2^ADDR_WIDTH (FFFF -> 0000 at 16 bits), then go to ISSUE.
- Both edges in the same cycle: examine wins; examine_next is dropped.
- Any edge outside IDLE is dropped. It is not queued. Prev registers keep tracking, so no late request appears.
- ISSUE, one cycle: mem_rd=1, examine_latch=1, timeout <= 0, counter <= 0. Then go to WAIT.
- mem_rd is high only in ISSUE.
- WAIT: examine_latch=1.
  - mem_rvalid=1: data_leds <= mem_rdata, addr_leds <= mem_addr, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without rvalid: data_leds <= 8'hFF, addr_leds <= mem_addr, timeout <= 1, go to DONE.
  - rvalid and the final count in the same cycle: rvalid wins; timeout stays 0.
- mem_rvalid is ignored in IDLE, ISSUE and DONE.
- DONE, one cycle: examine_latch=0, then go to IDLE.
- Latency: edge at cycle N -> mem_rd at N+1. rvalid at cycle M -> data_leds/addr_leds updated at M+1, examine_latch low from M+1. Fastest edge-to-LED time is 3 cycles.
- LEDs hold their value until the next completed read or reset. timeout holds until the next ISSUE.
- Reset mid-operation (any state): all outputs return to reset values next cycle. A late mem_rvalid after reset is ignored.
- examine_next after reset reads address 0001 (addr_leds=0 + 1).

Test Plan:
- Reset, addr_sw=16'h1234, pulse examine. Memory returns 8'hA5 two cycles after mem_rd. Required: mem_rd high exactly 1 cycle with mem_addr=1234, then addr_leds=1234, data_leds=A5, examine_latch high from ISSUE to rvalid, timeout=0.
- After the above, hold examine_next high for 20 cycles, memory returning 8'h3C. Required: exactly one read at 1235; addr_leds=1235, data_leds=3C.
- addr_sw=16'hFFFF, examine, then examine_next. Required: second read at mem_addr=0000 (wrap); addr_leds=0000.
- TIMEOUT_CYCLES=8, examine at 16'h0040, never assert rvalid. Required: after 8 WAIT cycles data_leds=FF, timeout=1, examine_latch=0. Next examine clears timeout in its ISSUE cycle.
- examine and examine_next rise in the same cycle with addr_sw=0x0100, addr_leds=0x0010. Required: single read at 0100. A second examine edge during WAIT produces no extra mem_rd.
- Assert reset during WAIT, then drive mem_rvalid=1 with 8'h77 one cycle later. Required: all outputs 0, state IDLE, data_leds stays 00.
